// File: rtl/gray_updown_counter.sv
// Registered up/down counter holding binary and Gray copies of one count.
// Loads take binary or Gray input; WRAP selects wrap-around or saturation at the bounds.
module gray_updown_counter #(
  parameter int N    = 8,
  parameter bit WRAP = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic         load_mode,
  input  logic [N-1:0] din,
  output logic [N-1:0] bin_q,
  output logic [N-1:0] gray_q,
  output logic         wrap,
  output logic         sat
);

  localparam logic [N-1:0] MAX_VAL = '1;
  localparam logic [N-1:0] MIN_VAL = '0;

  logic [N-1:0] bin_d;
  logic [N-1:0] gray_d;
  logic         wrap_d;
  logic         sat_d;

  function automatic logic [N-1:0] b2g(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    sat_d  = 1'b0;
    if (load) begin
      bin_d = load_mode ? g2b(din) : din;
    end else if (en) begin
      if (up) begin
        if (bin_q == MAX_VAL) begin
          if (WRAP) begin
            bin_d  = MIN_VAL;
            wrap_d = 1'b1;
          end else begin
            sat_d = 1'b1;
          end
        end else begin
          bin_d = bin_q + 1'b1;
        end
      end else begin
        if (bin_q == MIN_VAL) begin
          if (WRAP) begin
            bin_d  = MAX_VAL;
            wrap_d = 1'b1;
          end else begin
            sat_d = 1'b1;
          end
        end else begin
          bin_d = bin_q - 1'b1;
        end
      end
    end
    // Gray always tracks the next binary value so the two copies can never diverge.
    gray_d = b2g(bin_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap   <= 1'b0;
      sat    <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap   <= wrap_d;
      sat    <= sat_d;
    end
  end

endmodule

// File: tb/tb_gray_updown_counter.sv
// Scoreboard bench for gray_updown_counter: a wrapping and a saturating instance
// share stimulus; a reference model predicts both every cycle.
module tb_gray_updown_counter;

  typedef struct packed {
    logic [7:0] bin;
    logic [7:0] gray;
    logic       wrap;
    logic       sat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, up, load, load_mode;
  logic [7:0] din;
  logic [7:0] w_bin, w_gray, s_bin, s_gray;
  logic       w_wrap, w_sat, s_wrap, s_sat;

  exp_t q_w[$];
  exp_t q_s[$];
  int   m_w, m_s;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  gray_updown_counter #(.N(8), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_mode(load_mode),
    .din(din), .bin_q(w_bin), .gray_q(w_gray), .wrap(w_wrap), .sat(w_sat)
  );

  gray_updown_counter #(.N(8), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_mode(load_mode),
    .din(din), .bin_q(s_bin), .gray_q(s_gray), .wrap(s_wrap), .sat(s_sat)
  );

  wire exp_t act_w = {w_bin, w_gray, w_wrap, w_sat};
  wire exp_t act_s = {s_bin, s_gray, s_wrap, s_sat};

  task automatic model_inst(input bit wrapmode, inout int m, input bit r, l, lm, e, u,
                            input logic [7:0] d, output exp_t x);
    logic [7:0] b;
    x.wrap = 1'b0;
    x.sat  = 1'b0;
    if (r) m = 0;
    else if (l) begin
      if (lm) begin
        for (int i = 0; i < 8; i++) b[i] = ^(d >> i);
        m = int'(b);
      end else m = int'(d);
    end else if (e) begin
      if (u) begin
        if (m == 255) begin
          if (wrapmode) begin m = 0; x.wrap = 1'b1; end
          else x.sat = 1'b1;
        end else m = m + 1;
      end else begin
        if (m == 0) begin
          if (wrapmode) begin m = 255; x.wrap = 1'b1; end
          else x.sat = 1'b1;
        end else m = m - 1;
      end
    end
    x.bin  = m[7:0];
    x.gray = x.bin ^ (x.bin >> 1);
  endtask

  // Drive one command, predict both instances, then wait for the edge that applies it.
  task automatic apply(input bit r, l, lm, e, u, input logic [7:0] d);
    exp_t xw, xs;
    rst = r; load = l; load_mode = lm; en = e; up = u; din = d;
    model_inst(1'b1, m_w, r, l, lm, e, u, d, xw);
    model_inst(1'b0, m_s, r, l, lm, e, u, d, xs);
    q_w.push_back(xw);
    q_s.push_back(xs);
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp(output exp_t ew, output exp_t es);
    ew = '0;
    es = '0;
    if (q_w.size() == 0 || q_s.size() == 0) begin
      bad++;
      total++;
      $display("FAIL scoreboard_empty got=%0d/%0d entries required>0", q_w.size(), q_s.size());
    end else begin
      ew = q_w.pop_front();
      es = q_s.pop_front();
    end
  endtask

  task automatic test_reset();
    exp_t ew, es;
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      pop_exp(ew, es);
      total++;
      if (act_w !== ew) begin bad++; $display("FAIL reset_wrap got=%h required=%h", act_w, ew); end
      total++;
      if (act_s !== es) begin bad++; $display("FAIL reset_sat got=%h required=%h", act_s, es); end
    end
    total++;
    if (act_w !== 18'h0) begin bad++; $display("FAIL reset_zero got=%h required=0", act_w); end
  endtask

  task automatic test_count_up();
    exp_t ew, es;
    logic [7:0] prev;
    prev = w_gray;
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      pop_exp(ew, es);
      total++;
      if (act_w !== ew) begin bad++; $display("FAIL count_up_wrap step%0d got=%h required=%h", k, act_w, ew); end
      total++;
      if (act_s !== es) begin bad++; $display("FAIL count_up_sat step%0d got=%h required=%h", k, act_s, es); end
      total++;
      if ($countones(prev ^ w_gray) != 1) begin
        bad++; $display("FAIL gray_hamming step%0d got=%h->%h required one bit change", k, prev, w_gray);
      end
      prev = w_gray;
    end
    total++;
    if (w_bin !== 8'd5 || w_gray !== 8'b00000111) begin
      bad++; $display("FAIL count_up_five got=%h/%h required=05/07", w_bin, w_gray);
    end
  endtask

  task automatic test_wrap();
    exp_t ew, es;
    logic [7:0] prev;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd255);
    pop_exp(ew, es);
    total++;
    if (act_w !== ew || w_gray !== 8'h80) begin bad++; $display("FAIL load_bin255 got=%h required=%h", act_w, ew); end
    prev = w_gray;
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    pop_exp(ew, es);
    total++;
    if (act_w !== ew || w_bin !== 8'h00 || w_gray !== 8'h00 || w_wrap !== 1'b1) begin
      bad++; $display("FAIL wrap_up got=%h required=%h", act_w, ew);
    end
    total++;
    if ($countones(prev ^ w_gray) != 1) begin bad++; $display("FAIL wrap_hamming got=%h->%h required one bit", prev, w_gray); end
    total++;
    if (act_s !== es || s_sat !== 1'b1) begin bad++; $display("FAIL sat_up_top got=%h required=%h", act_s, es); end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    pop_exp(ew, es);
    total++;
    if (act_w !== ew || w_wrap !== 1'b0) begin bad++; $display("FAIL wrap_pulse_len got=%h required=%h", act_w, ew); end
    total++;
    if (act_s !== es) begin bad++; $display("FAIL sat_pulse_len got=%h required=%h", act_s, es); end
  endtask

  task automatic test_gray_load();
    exp_t ew, es;
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80);
    pop_exp(ew, es);
    total++;
    if (act_w !== ew || w_bin !== 8'hFF || w_gray !== 8'h80) begin
      bad++; $display("FAIL load_gray80 got=%h required=%h", act_w, ew);
    end
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    pop_exp(ew, es);
    total++;
    if (act_w !== ew || w_bin !== 8'hFE || w_gray !== 8'h81) begin
      bad++; $display("FAIL down_after_gray got=%h required=%h", act_w, ew);
    end
    total++;
    if (act_s !== es) begin bad++; $display("FAIL down_after_gray_sat got=%h required=%h", act_s, es); end
  endtask

  task automatic test_saturate();
    exp_t ew, es;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    pop_exp(ew, es);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    pop_exp(ew, es);
    total++;
    if (act_s !== es || s_bin !== 8'h00 || s_sat !== 1'b1 || s_wrap !== 1'b0) begin
      bad++; $display("FAIL sat_bottom got=%h required=%h", act_s, es);
    end
    total++;
    if (act_w !== ew || w_bin !== 8'hFF || w_wrap !== 1'b1) begin
      bad++; $display("FAIL wrap_down got=%h required=%h", act_w, ew);
    end
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
    pop_exp(ew, es);
    total++;
    if (act_s !== es || s_sat !== 1'b0) begin bad++; $display("FAIL load_clears_sat got=%h required=%h", act_s, es); end
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    pop_exp(ew, es);
    total++;
    if (act_s !== es || s_bin !== 8'hFF || s_gray !== 8'h80 || s_sat !== 1'b1) begin
      bad++; $display("FAIL sat_top got=%h required=%h", act_s, es);
    end
  endtask

  task automatic test_priority();
    exp_t ew, es;
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C);
    pop_exp(ew, es);
    total++;
    if (act_w !== ew || w_bin !== 8'h3C) begin bad++; $display("FAIL load_over_en got=%h required=%h", act_w, ew); end
    apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77);
    pop_exp(ew, es);
    total++;
    if (act_w !== ew || w_bin !== 8'h00) begin bad++; $display("FAIL rst_over_load got=%h required=%h", act_w, ew); end
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
    pop_exp(ew, es);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12);
      pop_exp(ew, es);
      total++;
      if (act_w !== ew || w_bin !== 8'hA5 || w_wrap !== 1'b0) begin
        bad++; $display("FAIL hold_wrap cyc%0d got=%h required=%h", k, act_w, ew);
      end
      total++;
      if (act_s !== es || s_bin !== 8'hA5 || s_sat !== 1'b0) begin
        bad++; $display("FAIL hold_sat cyc%0d got=%h required=%h", k, act_s, es);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t ew, es;
    bit r, l, lm, e, u;
    for (int k = 0; k < 60; k++) begin
      r  = ($urandom_range(0, 19) == 0);
      l  = ($urandom_range(0, 5) == 0);
      lm = $urandom_range(0, 1);
      e  = ($urandom_range(0, 3) != 0);
      u  = ($urandom_range(0, 2) != 0);
      apply(r, l, lm, e, u, 8'($urandom_range(0, 255)));
      pop_exp(ew, es);
      total++;
      if (act_w !== ew) begin bad++; $display("FAIL b2b_wrap cyc%0d got=%h required=%h", k, act_w, ew); end
      total++;
      if (act_s !== es) begin bad++; $display("FAIL b2b_sat cyc%0d got=%h required=%h", k, act_s, es); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_mode = 1'b0; din = 8'h00;
    m_w = 0;
    m_s = 0;
    test_reset();
    test_count_up();
    test_wrap();
    test_gray_load();
    test_saturate();
    test_priority();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
